// File: rtl/lsu_dbus_ctrl_pkg.sv
// Shared types and constants for the LSU data-bus controller.
// The request payload, the tag bit position in capability store data,
// and the access size encodings live here.
package lsu_dbus_ctrl_pkg;

    // Bit position of the capability tag inside lsu_req_info_t.wdata
    localparam int MEM_TAG = 64;

    // data_type encodings
    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;
    localparam logic [1:0] DT_CAP  = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic        is_load;
        logic        is_cap;
        logic [1:0]  data_type;
        logic        sign_ext;
        logic [64:0] wdata;           // {tag, hi word, lo word}
        logic        cheri_err;
        logic        align_err_only;
        logic [4:0]  cheri_cause;
    } lsu_req_info_t;

    // Byte lanes touched by an access of the given size at the given offset
    function automatic logic [3:0] be_decode(logic [1:0] data_type, logic [1:0] offset);
        logic [3:0] be;
        case (data_type)
            DT_BYTE: be = 4'(4'b0001 << offset);
            DT_HALF: be = 4'(4'b0011 << offset);
            default: be = 4'hF;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_dbus_ctrl_load_align.sv
// lsu_load_align: purely combinational load data alignment.
// Moves the addressed byte/half down to bit 0 and sign- or zero-extends it;
// word and capability accesses pass the bus word through unchanged.
module lsu_load_align
    import lsu_dbus_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  data_type,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Shift addressed lanes to the bottom, then extend to 32 bits
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (data_type)
            DT_BYTE: result = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            DT_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// lsu_dbus_ctrl: turns one LSU request at a time into bus transactions.
// Faulting requests complete without touching the bus. Capability accesses
// take two word beats (lo at the aligned address, hi at +4) when the build
// defines CHERIOT_LSU_CAP_EN; otherwise every access is a single beat.
// Only one bus transaction is ever outstanding.
module lsu_dbus_ctrl
    import lsu_dbus_ctrl_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          lsu_req_i,
    input  lsu_req_info_t lsu_req_info_i,
    output logic          lsu_req_done_o,
    output logic          data_req_o,
    input  logic          data_gnt_i,
    output logic [31:0]   data_addr_o,
    output logic          data_we_o,
    output logic [3:0]    data_be_o,
    output logic [32:0]   data_wdata_o,
    input  logic          data_rvalid_i,
    input  logic [32:0]   data_rdata_i,
    input  logic          data_err_i,
    output logic          resp_valid_o,
    output logic [64:0]   resp_rdata_o,
    output logic          resp_err_o,
    output logic          resp_cheri_err_o,
    output logic [4:0]    resp_cheri_cause_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR0,
        DATA0,
        ADDR1,
        DATA1,
        FAULT
    } state_t;

    state_t        state_q, state_d;
    lsu_req_info_t info_q;
    logic [31:0]   lo_q;          // low word of a capability load
    logic          tag_q;         // tag seen on beat 0
    logic          beat0_latch;
    logic          cap_access;
    logic [31:0]   base_addr;
    logic [31:0]   align_result;
    logic [64:0]   load_rdata;

`ifdef CHERIOT_LSU_CAP_EN
    assign cap_access = info_q.is_cap;
`else
    // Capability fields are carried in the payload but never acted on
    logic unused_cap;
    assign unused_cap = ^{info_q.is_cap, info_q.wdata[64:32]};
    assign cap_access = 1'b0;
`endif

    assign base_addr = {info_q.addr[31:2], 2'b00};

    lsu_load_align u_load_align (
        .rdata     (data_rdata_i[31:0]),
        .offset    (info_q.addr[1:0]),
        .data_type (info_q.data_type),
        .sign_ext  (info_q.sign_ext),
        .result    (align_result)
    );

    // Bus address/control: stable for the whole life of a request
    always_comb begin
        data_addr_o = (state_q == ADDR1) ? base_addr + 32'd4 : base_addr;
        data_we_o   = ~info_q.is_load;
        data_be_o   = be_decode(info_q.data_type, info_q.addr[1:0]);
        if (cap_access)
            data_wdata_o = {info_q.wdata[MEM_TAG],
                            (state_q == ADDR1) ? info_q.wdata[63:32] : info_q.wdata[31:0]};
        else
            data_wdata_o = {1'b0, 32'(info_q.wdata[31:0] << {info_q.addr[1:0], 3'b000})};
    end

    // State, captured request and beat-0 capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            info_q  <= '0;
            lo_q    <= '0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (lsu_req_done_o)
                info_q <= lsu_req_info_i;
            if (beat0_latch) begin
                lo_q  <= data_rdata_i[31:0];
                tag_q <= data_rdata_i[32];
            end
        end
    end

    // Next state, handshakes and completion response
    always_comb begin
        state_d            = state_q;
        lsu_req_done_o     = 1'b0;
        data_req_o         = 1'b0;
        beat0_latch        = 1'b0;
        resp_valid_o       = 1'b0;
        resp_err_o         = 1'b0;
        resp_cheri_err_o   = 1'b0;
        resp_cheri_cause_o = '0;
        load_rdata         = '0;

        case (state_q)
            IDLE: begin
                lsu_req_done_o = lsu_req_i;
                if (lsu_req_i)
                    state_d = (lsu_req_info_i.cheri_err || lsu_req_info_i.align_err_only)
                              ? FAULT : ADDR0;
            end
            ADDR0: begin
                data_req_o = 1'b1;
                if (data_gnt_i)
                    state_d = DATA0;
            end
            DATA0: begin
                if (data_rvalid_i) begin
                    if (data_err_i) begin
                        resp_valid_o = 1'b1;
                        resp_err_o   = 1'b1;
                        load_rdata   = {33'b0, align_result};
                        state_d      = IDLE;
                    end else if (cap_access) begin
                        beat0_latch = 1'b1;
                        state_d     = ADDR1;
                    end else begin
                        resp_valid_o = 1'b1;
                        load_rdata   = {33'b0, align_result};
                        state_d      = IDLE;
                    end
                end
            end
            ADDR1: begin
                data_req_o = 1'b1;
                if (data_gnt_i)
                    state_d = DATA1;
            end
            DATA1: begin
                if (data_rvalid_i) begin
                    resp_valid_o = 1'b1;
                    resp_err_o   = data_err_i;
                    load_rdata   = {tag_q & data_rdata_i[32] & ~data_err_i,
                                    data_rdata_i[31:0], lo_q};
                    state_d      = IDLE;
                end
            end
            FAULT: begin
                resp_valid_o       = 1'b1;
                resp_cheri_err_o   = 1'b1;
                resp_cheri_cause_o = info_q.cheri_cause;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Stores return no data
        resp_rdata_o = (resp_valid_o && info_q.is_load) ? load_rdata : '0;
    end

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// Self-checking bench for lsu_dbus_ctrl: directed cases followed by random
// requests; the bench plays the bus and predicts every beat and response.
module tb_lsu_dbus_ctrl;
    import lsu_dbus_ctrl_pkg::*;

`ifdef CHERIOT_LSU_CAP_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lsu_req = 1'b0;
    lsu_req_info_t lsu_req_info = '0;
    logic          lsu_req_done;
    logic          data_req;
    logic          data_gnt = 1'b0;
    logic [31:0]   data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [32:0]   data_wdata;
    logic          data_rvalid = 1'b0;
    logic [32:0]   data_rdata = '0;
    logic          data_err = 1'b0;
    logic          resp_valid;
    logic [64:0]   resp_rdata;
    logic          resp_err;
    logic          resp_cheri_err;
    logic [4:0]    resp_cheri_cause;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [64:0] last_rdata;

    always #5 clk = ~clk;

    lsu_dbus_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .lsu_req_i          (lsu_req),
        .lsu_req_info_i     (lsu_req_info),
        .lsu_req_done_o     (lsu_req_done),
        .data_req_o         (data_req),
        .data_gnt_i         (data_gnt),
        .data_addr_o        (data_addr),
        .data_we_o          (data_we),
        .data_be_o          (data_be),
        .data_wdata_o       (data_wdata),
        .data_rvalid_i      (data_rvalid),
        .data_rdata_i       (data_rdata),
        .data_err_i         (data_err),
        .resp_valid_o       (resp_valid),
        .resp_rdata_o       (resp_rdata),
        .resp_err_o         (resp_err),
        .resp_cheri_err_o   (resp_cheri_err),
        .resp_cheri_cause_o (resp_cheri_cause)
    );

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: lanes enabled by an access
    function automatic logic [3:0] ref_be(lsu_req_info_t i);
        int off;
        off = int'(i.addr[1:0]);
        if (i.data_type == DT_BYTE) return 4'(1 << off);
        if (i.data_type == DT_HALF) return 4'(3 << off);
        return 4'hF;
    endfunction

    // Reference: load result from the beats returned by the bus
    function automatic logic [64:0] ref_load(lsu_req_info_t i, bit cap,
                                             logic [32:0] rd0, logic [32:0] rd1);
        logic [31:0] w;
        int          v;
        if (cap) return {rd0[32] & rd1[32], rd1[31:0], rd0[31:0]};
        w = rd0[31:0] / (32'd1 << (8 * int'(i.addr[1:0])));
        if (i.data_type == DT_BYTE)
            v = i.sign_ext ? int'($signed(w[7:0])) : int'(w[7:0]);
        else if (i.data_type == DT_HALF)
            v = i.sign_ext ? int'($signed(w[15:0])) : int'(w[15:0]);
        else
            v = int'(w);
        return {33'b0, 32'(v)};
    endfunction

    // Issue one request and act as the bus; gnt delays per beat, fixed rvalid delay
    task automatic run_txn(input lsu_req_info_t info, input int gd0, input int gd1,
                           input int rdly, input logic [32:0] rd0, input logic [32:0] rd1,
                           input logic e0, input logic e1);
        bit          cap;
        int          nb;
        int          gd;
        logic [31:0] base;
        logic [32:0] rd;
        logic        e;
        logic [32:0] exp_wd;
        bit          last;
        cap  = CAP_EN && info.is_cap;
        nb   = cap ? 2 : 1;
        base = info.addr & 32'hFFFF_FFFC;

        @(negedge clk);
        lsu_req      = 1'b1;
        lsu_req_info = info;
        #1 chk("req_done", 65'(lsu_req_done), 65'(1));
        @(posedge clk);
        #1 lsu_req = 1'b0;

        if (info.cheri_err || info.align_err_only) begin
            @(negedge clk);
            #1;
            chk("fault_valid", 65'(resp_valid), 65'(1));
            chk("fault_cheri", 65'(resp_cheri_err), 65'(1));
            chk("fault_cause", 65'(resp_cheri_cause), 65'(info.cheri_cause));
            chk("fault_nobus", 65'(data_req), 65'(0));
            chk("fault_err", 65'(resp_err), 65'(0));
            @(posedge clk);
        end else begin
            for (int b = 0; b < nb; b++) begin
                gd = (b == 0) ? gd0 : gd1;
                rd = (b == 0) ? rd0 : rd1;
                e  = (b == 0) ? e0 : e1;
                if (cap)
                    exp_wd = {info.wdata[64], (b == 0) ? info.wdata[31:0] : info.wdata[63:32]};
                else
                    exp_wd = {1'b0, info.wdata[31:0] * (32'd1 << (8 * int'(info.addr[1:0])))};
                for (int c = 0; c <= gd; c++) begin
                    @(negedge clk);
                    data_gnt = (c == gd);
                    #1;
                    chk("bus_req", 65'(data_req), 65'(1));
                    chk("bus_addr", 65'(data_addr), 65'(base + 32'(4 * b)));
                    chk("bus_be", 65'(data_be), 65'(ref_be(info)));
                    chk("bus_we", 65'(data_we), 65'(!info.is_load));
                    if (!info.is_load) chk("bus_wdata", 65'(data_wdata), 65'(exp_wd));
                    chk("no_resp_addr", 65'(resp_valid), 65'(0));
                    @(posedge clk);
                    #1 data_gnt = 1'b0;
                end
                for (int d = 0; d < rdly; d++) begin
                    @(negedge clk);
                    #1;
                    chk("idle_bus", 65'(data_req), 65'(0));
                    chk("wait_resp", 65'(resp_valid), 65'(0));
                    @(posedge clk);
                end
                @(negedge clk);
                data_rvalid = 1'b1;
                data_rdata  = rd;
                data_err    = e;
                #1;
                last = (b == nb - 1) || e;
                if (last) begin
                    last_rdata = resp_rdata;
                    chk("resp_valid", 65'(resp_valid), 65'(1));
                    chk("resp_err", 65'(resp_err), 65'(e));
                    chk("resp_cheri", 65'(resp_cheri_err), 65'(0));
                    if (e)
                        chk("err_tag", 65'(resp_rdata[64]), 65'(0));
                    else if (info.is_load)
                        chk("resp_rdata", resp_rdata, ref_load(info, cap, rd0, rd1));
                end else begin
                    chk("beat0_noresp", 65'(resp_valid), 65'(0));
                end
                @(posedge clk);
                #1;
                data_rvalid = 1'b0;
                data_err    = 1'b0;
                if (last) break;
            end
        end
        @(negedge clk);
        #1;
        chk("after_valid", 65'(resp_valid), 65'(0));
        chk("after_req", 65'(data_req), 65'(0));
        chk("after_rdata", resp_rdata, 65'(0));
    endtask

    function automatic lsu_req_info_t mk(logic [31:0] addr, logic ld, logic [1:0] dt,
                                         logic sx, logic [64:0] wd);
        lsu_req_info_t i;
        i                = '0;
        i.addr           = addr;
        i.is_load        = ld;
        i.is_cap         = (dt == DT_CAP);
        i.data_type      = dt;
        i.sign_ext       = sx;
        i.wdata          = wd;
        return i;
    endfunction

    initial begin
        lsu_req_info_t info;
        logic [1:0]    dt;
        logic [31:0]   a;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        lsu_req = 1'b1;
        #1;
        chk("rst_req", 65'(data_req), 65'(0));
        chk("rst_valid", 65'(resp_valid), 65'(0));
        chk("rst_err", 65'(resp_err), 65'(0));
        chk("rst_cheri", 65'(resp_cheri_err), 65'(0));
        chk("rst_done", 65'(lsu_req_done), 65'(1));
        lsu_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Sign-extended byte load from the top lane
        info = mk(32'h1003, 1'b1, DT_BYTE, 1'b1, '0);
        run_txn(info, 0, 0, 0, 33'h0_8000_0000, '0, 1'b0, 1'b0);
        chk("byte_sext", 65'(last_rdata[31:0]), 65'(32'hFFFF_FF80));

        // Two-beat capability load
        info = mk(32'h2000, 1'b1, DT_CAP, 1'b0, '0);
        run_txn(info, 0, 0, 1, 33'h1_1111_1111, 33'h1_2222_2222, 1'b0, 1'b0);
        if (CAP_EN) chk("cap_load", last_rdata, {1'b1, 32'h2222_2222, 32'h1111_1111});
        else        chk("cap_load_1beat", last_rdata, 65'(32'h1111_1111));

        // Capability store with grant held off three cycles
        info = mk(32'h3000, 1'b0, DT_CAP, 1'b0, {1'b1, 32'hCAFE_F00D, 32'hDEAD_BEEF});
        run_txn(info, 3, 1, 0, '0, '0, 1'b0, 1'b0);

        // CHERI fault never reaches the bus
        info = mk(32'h3100, 1'b1, DT_WORD, 1'b0, '0);
        info.cheri_err   = 1'b1;
        info.cheri_cause = 5'h02;
        run_txn(info, 0, 0, 0, '0, '0, 1'b0, 1'b0);

        // Capability load with a bus error on beat 0
        info = mk(32'h2100, 1'b1, DT_CAP, 1'b0, '0);
        run_txn(info, 0, 0, 0, 33'h1_5555_5555, 33'h1_6666_6666, 1'b1, 1'b0);

        // Reset while waiting for read data; the late rvalid must be ignored
        @(negedge clk);
        lsu_req      = 1'b1;
        lsu_req_info = mk(32'h4000, 1'b1, DT_WORD, 1'b0, '0);
        @(posedge clk);
        #1 lsu_req = 1'b0;
        @(negedge clk);
        data_gnt = 1'b1;
        #1 chk("rstmid_req", 65'(data_req), 65'(1));
        @(posedge clk);
        #1 data_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        data_rvalid = 1'b1;
        data_rdata  = 33'h0_1234_5678;
        #1;
        chk("rstmid_noresp", 65'(resp_valid), 65'(0));
        chk("rstmid_nobus", 65'(data_req), 65'(0));
        lsu_req = 1'b1;
        #1 chk("rstmid_idle", 65'(lsu_req_done), 65'(1));
        lsu_req = 1'b0;
        @(posedge clk);
        #1 data_rvalid = 1'b0;
        info = mk(32'h4004, 1'b1, DT_WORD, 1'b0, '0);
        run_txn(info, 1, 0, 0, 33'h0_A5A5_5A5A, '0, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            dt = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (dt == DT_HALF) a[0] = 1'b0;
            if (dt == DT_WORD || dt == DT_CAP) a[1:0] = 2'b00;
            info = mk(a, 1'($urandom_range(0, 1)), dt, 1'($urandom_range(0, 1)),
                      {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)});
            info.cheri_err      = ($urandom_range(0, 7) == 0);
            info.align_err_only = ($urandom_range(0, 9) == 0);
            info.cheri_cause    = 5'($urandom);
            run_txn(info, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                    {1'($urandom_range(0, 1)), 32'($urandom)},
                    {1'($urandom_range(0, 1)), 32'($urandom)},
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
